led_matrix_driver: RTL and testbench

- Self-contained HUB75 driver for a 32x32 RGB LED matrix panel, 1/16 scan, two half-panels shifted in parallel.
- Generates an animated colour test pattern internally; there is no pixel-data input.
- Produces the serial clock, latch, output-enable and 4-bit row address.
- Mirrors an animation step counter on eight status LEDs.
- Top-level block connected directly to FPGA pins.

---
 rtl/led_matrix_driver_pkg.sv | 24 ++
 rtl/led_matrix_driver_if.sv | 21 ++
 rtl/led_matrix_driver_tick_gen.sv | 31 +++
 rtl/led_matrix_driver.sv | 152 +++++++++++++++
 tb/tb_led_matrix_driver.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/led_matrix_driver_pkg.sv
// Shared types and constants for the HUB75 LED matrix driver.
package led_matrix_driver_pkg;

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH
    } state_e;

    localparam int unsigned ROWS_HALF = 16;
    localparam int unsigned ADDR_W    = 4;

    // Ticks per half shift-clock period, never below one system cycle.
    function automatic int unsigned calc_div(input int unsigned base_freq,
                                             input int unsigned target_freq);
        int unsigned d;
        if (target_freq == 0) begin
            return 1;
        end
        d = base_freq / (2 * target_freq);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/led_matrix_driver_if.sv
// HUB75 panel-side signal bundle: the driver is master, the panel is slave.
interface led_matrix_driver_if;
    import led_matrix_driver_pkg::*;

    logic              r0, g0, b0;
    logic              r1, g1, b1;
    logic [ADDR_W-1:0] addr;
    logic              clk_o;
    logic              latch;
    logic              oe;
    logic [7:0]        leds;

    modport master (
        output r0, g0, b0, r1, g1, b1, addr, clk_o, latch, oe, leds
    );

    modport slave (
        input r0, g0, b0, r1, g1, b1, addr, clk_o, latch, oe, leds
    );

endinterface

// File: rtl/led_matrix_driver_tick_gen.sv
// Tick enable: one pulse every DIV cycles, first pulse right after reset release.
module led_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic CLK_I,
    input  logic RSTN_I,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = (cnt_q == '0);
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_matrix_driver.sv
// HUB75 driver for a 32x32 1/16-scan panel with an internal animated test pattern.
module led_matrix_driver
    import led_matrix_driver_pkg::*;
#(
    parameter int unsigned BASE_FREQ   = 12000000,
    parameter int unsigned TARGET_FREQ = 6000000,
    parameter int unsigned COLS        = 32,
    parameter int unsigned FRAME_DIV   = 16
) (
    input  logic CLK_I,
    input  logic RSTN_I,
    output logic R0, G0, B0,
    output logic R1, G1, B1,
    output logic RA, RB, RC, RD,
    output logic CLK_O,
    output logic LATCH,
    output logic OE,
    output logic LED1, LED2, LED3, LED4, LED5, LED6, LED7, LED8
);

    localparam int unsigned DIV   = calc_div(BASE_FREQ, TARGET_FREQ);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned FRM_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic tick;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .CLK_I  (CLK_I),
        .RSTN_I (RSTN_I),
        .tick   (tick)
    );

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [7:0]        step_q, step_d;
    logic [2:0]        rgb0_q, rgb0_d;
    logic [2:0]        rgb1_q, rgb1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clk_o_q, clk_o_d;
    logic              latch_q, latch_d;
    logic              oe_q, oe_d;
    logic [2:0]        pat;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        phase_d = phase_q;
        row_d   = row_q;
        frame_d = frame_q;
        step_d  = step_q;
        rgb0_d  = rgb0_q;
        rgb1_d  = rgb1_q;
        addr_d  = addr_q;
        clk_o_d = clk_o_q;
        latch_d = latch_q;
        oe_d    = oe_q;
        pat     = 3'(col_q) + row_q[2:0] + step_q[2:0];

        if (tick) begin
            case (state_q)
                ST_SHIFT: begin
                    oe_d    = 1'b0;
                    latch_d = 1'b0;
                    if (!phase_q) begin
                        clk_o_d = 1'b0;
                        rgb0_d  = pat;
                        rgb1_d  = ~pat;
                        phase_d = 1'b1;
                    end else begin
                        clk_o_d = 1'b1;
                        phase_d = 1'b0;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            state_d = ST_BLANK;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                ST_BLANK: begin
                    oe_d    = 1'b1;
                    clk_o_d = 1'b0;
                    rgb0_d  = '0;
                    rgb1_d  = '0;
                    addr_d  = row_q;
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    latch_d = 1'b1;
                    oe_d    = 1'b1;
                    clk_o_d = 1'b0;
                    rgb0_d  = '0;
                    rgb1_d  = '0;
                    row_d   = row_q + ADDR_W'(1);
                    state_d = ST_SHIFT;
                    // Animation step advances once FRAME_DIV full scans have completed.
                    if (row_q == ADDR_W'(ROWS_HALF - 1)) begin
                        if (frame_q == FRM_W'(FRAME_DIV - 1)) begin
                            frame_d = '0;
                            step_d  = step_q + 8'd1;
                        end else begin
                            frame_d = frame_q + FRM_W'(1);
                        end
                    end
                end
                default: state_d = ST_SHIFT;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_q <= ST_SHIFT;
            col_q   <= '0;
            phase_q <= 1'b0;
            row_q   <= '0;
            frame_q <= '0;
            step_q  <= '0;
            rgb0_q  <= '0;
            rgb1_q  <= '0;
            addr_q  <= '0;
            clk_o_q <= 1'b0;
            latch_q <= 1'b0;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            step_q  <= step_d;
            rgb0_q  <= rgb0_d;
            rgb1_q  <= rgb1_d;
            addr_q  <= addr_d;
            clk_o_q <= clk_o_d;
            latch_q <= latch_d;
            oe_q    <= oe_d;
        end
    end

    assign {B0, G0, R0} = rgb0_q;
    assign {B1, G1, R1} = rgb1_q;
    assign {RD, RC, RB, RA} = addr_q;
    assign CLK_O = clk_o_q;
    assign LATCH = latch_q;
    assign OE    = oe_q;
    assign {LED8, LED7, LED6, LED5, LED4, LED3, LED2, LED1} = step_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Self-checking bench: three driver configurations against a cycle-indexed reference model.
module tb_led_matrix_driver;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    led_matrix_driver_if if0 ();
    led_matrix_driver_if if1 ();
    led_matrix_driver_if if2 ();

    led_matrix_driver u0 (
        .CLK_I(clk), .RSTN_I(rstn),
        .R0(if0.r0), .G0(if0.g0), .B0(if0.b0),
        .R1(if0.r1), .G1(if0.g1), .B1(if0.b1),
        .RA(if0.addr[0]), .RB(if0.addr[1]), .RC(if0.addr[2]), .RD(if0.addr[3]),
        .CLK_O(if0.clk_o), .LATCH(if0.latch), .OE(if0.oe),
        .LED1(if0.leds[0]), .LED2(if0.leds[1]), .LED3(if0.leds[2]), .LED4(if0.leds[3]),
        .LED5(if0.leds[4]), .LED6(if0.leds[5]), .LED7(if0.leds[6]), .LED8(if0.leds[7])
    );

    led_matrix_driver #(.BASE_FREQ(12000000), .TARGET_FREQ(1000000)) u1 (
        .CLK_I(clk), .RSTN_I(rstn),
        .R0(if1.r0), .G0(if1.g0), .B0(if1.b0),
        .R1(if1.r1), .G1(if1.g1), .B1(if1.b1),
        .RA(if1.addr[0]), .RB(if1.addr[1]), .RC(if1.addr[2]), .RD(if1.addr[3]),
        .CLK_O(if1.clk_o), .LATCH(if1.latch), .OE(if1.oe),
        .LED1(if1.leds[0]), .LED2(if1.leds[1]), .LED3(if1.leds[2]), .LED4(if1.leds[3]),
        .LED5(if1.leds[4]), .LED6(if1.leds[5]), .LED7(if1.leds[6]), .LED8(if1.leds[7])
    );

    led_matrix_driver #(.COLS(2), .FRAME_DIV(1)) u2 (
        .CLK_I(clk), .RSTN_I(rstn),
        .R0(if2.r0), .G0(if2.g0), .B0(if2.b0),
        .R1(if2.r1), .G1(if2.g1), .B1(if2.b1),
        .RA(if2.addr[0]), .RB(if2.addr[1]), .RC(if2.addr[2]), .RD(if2.addr[3]),
        .CLK_O(if2.clk_o), .LATCH(if2.latch), .OE(if2.oe),
        .LED1(if2.leds[0]), .LED2(if2.leds[1]), .LED3(if2.leds[2]), .LED4(if2.leds[3]),
        .LED5(if2.leds[4]), .LED6(if2.leds[5]), .LED7(if2.leds[6]), .LED8(if2.leds[7])
    );

    // Packed view: [20:15] r0 g0 b0 r1 g1 b1, [14:11] addr, [10] clk_o, [9] latch, [8] oe, [7:0] leds
    localparam logic [20:0] RESET_VEC = 21'h000100;

    logic [20:0] act0, act1, act2;
    assign act0 = {if0.r0, if0.g0, if0.b0, if0.r1, if0.g1, if0.b1, if0.addr, if0.clk_o, if0.latch, if0.oe, if0.leds};
    assign act1 = {if1.r0, if1.g0, if1.b0, if1.r1, if1.g1, if1.b1, if1.addr, if1.clk_o, if1.latch, if1.oe, if1.leds};
    assign act2 = {if2.r0, if2.g0, if2.b0, if2.r1, if2.g1, if2.b1, if2.addr, if2.clk_o, if2.latch, if2.oe, if2.leds};

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Panel state after running k clean cycles since reset release.
    function automatic logic [20:0] expv(input int unsigned div, input int unsigned cols,
                                         input int unsigned fdiv, input int unsigned k);
        int unsigned t, rp, ri, pos, row, col, st, a;
        logic [2:0]  p;
        logic [20:0] v;
        t   = k / div;
        rp  = 2 * cols + 2;
        ri  = t / rp;
        pos = t % rp;
        row = ri % 16;
        v   = '0;
        if (pos < 2 * cols) begin
            col    = pos / 2;
            st     = (ri / (16 * fdiv)) % 256;
            p      = 3'((col + row + st) % 8);
            v[20]  = p[0];
            v[19]  = p[1];
            v[18]  = p[2];
            v[17]  = ~p[0];
            v[16]  = ~p[1];
            v[15]  = ~p[2];
            v[10]  = (pos % 2) == 1;
            a      = (ri == 0) ? 0 : (ri - 1) % 16;
        end else begin
            v[8]   = 1'b1;
            v[9]   = (pos == rp - 1);
            a      = row;
        end
        v[14:11] = 4'(a);
        v[7:0]   = 8'(((t + 1) / rp / (16 * fdiv)) % 256);
        return v;
    endfunction

    bit          model_valid = 0;
    bit          rst_seen    = 1;
    int unsigned kcnt        = 0;
    int unsigned last_k      = 0;

    always @(posedge clk) begin
        model_valid = 1;
        if (!rstn) begin
            rst_seen = 1;
            kcnt     = 0;
        end else begin
            rst_seen = 0;
            last_k   = kcnt;
            kcnt++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            if (rst_seen) begin
                chk("u0_reset", 32'(act0), 32'(RESET_VEC));
                chk("u1_reset", 32'(act1), 32'(RESET_VEC));
                chk("u2_reset", 32'(act2), 32'(RESET_VEC));
            end else begin
                chk("u0_model", 32'(act0), 32'(expv(1, 32, 16, last_k)));
                chk("u1_model", 32'(act1), 32'(expv(6, 32, 16, last_k)));
                chk("u2_model", 32'(act2), 32'(expv(1, 2, 1, last_k)));
                case (last_k)
                    2:     chk("u0_col1_rgb",    32'(act0[20:15]), 32'b100011);
                    10:    chk("u0_col5_upper",  32'(act0[20:18]), 32'b101);
                    64:    chk("u0_blank_ctl",   32'(act0[14:8]),  32'b0000001);
                    65:    chk("u0_latch_ctl",   32'(act0[10:8]),  32'b011);
                    66:    chk("u0_row1_col0",   32'(act0[20:11]), 32'b1000110000);
                    130:   chk("u0_row1_addr",   32'(act0[14:11]), 32'd1);
                    16895: chk("u0_step1_leds",  32'(act0[7:0]),   32'd1);
                    16896: chk("u0_step1_upper", 32'(act0[20:18]), 32'b100);
                    default: ;
                endcase
                case (last_k)
                    6:     chk("u1_clko_high", 32'(act1[10]), 32'd1);
                    11:    chk("u1_clko_hold", 32'(act1[10]), 32'd1);
                    12:    chk("u1_clko_low",  32'(act1[10]), 32'd0);
                    389:   chk("u1_pre_latch", 32'(act1[9]),  32'd0);
                    390:   chk("u1_latch",     32'(act1[9]),  32'd1);
                    24574: chk("u2_leds_255",  32'(act2[7:0]), 32'd255);
                    24575: chk("u2_leds_wrap", 32'(act2[7:0]), 32'd0);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        chk("init_reset_u0", 32'(act0), 32'(RESET_VEC));

        // Random run lengths and reset pulse widths.
        for (int i = 0; i < 3; i++) begin
            rstn = 1'b1;
            repeat ($urandom_range(1500, 200)) @(negedge clk);
            rstn = 1'b0;
            repeat ($urandom_range(4, 1)) @(negedge clk);
        end

        // Reset in the middle of row 7 shifting.
        rstn = 1'b1;
        repeat (7 * 66 + 10) @(negedge clk);
        chk("mid_row7_oe", 32'(act0[8]), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_reset_u0", 32'(act0), 32'(RESET_VEC));

        rstn = 1'b1;
        repeat (25000) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
